// File: rtl/srt_div_pkg.sv
// Shared types and constants for the SRT divider front/back ends.
package srt_div_pkg;
  localparam int          BIAS  = 127;
  localparam int          SIG_W = 24;
  localparam int          EXP_W = 10;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } ieee754_t;

  typedef enum logic [1:0] {IDLE, NORM, OUT} pre_state_t;

  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORMAL, CLS_INF, CLS_NAN} op_class_t;

  function automatic op_class_t classify(input ieee754_t x);
    if (x.exp == 8'h00) return (x.frac == '0) ? CLS_ZERO : CLS_SUB;
    if (x.exp == 8'hFF) return (x.frac == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction
endpackage

// File: rtl/srt_pre_processing_norm_step.sv
// One normalization step: shift left by min(NORM_STEP, leading zeros), adjust exponent.
module norm_step
  import srt_div_pkg::*;
#(
  parameter int NORM_STEP = 4
) (
  input  logic [SIG_W-1:0] sig_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic [SIG_W-1:0] sig_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             done
);
  logic [4:0] lz, k;

  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < SIG_W; i++)
      if (sig_in[i]) lz = 5'(SIG_W - 1 - i);
  end

  assign k       = (lz > 5'(NORM_STEP)) ? 5'(NORM_STEP) : lz;
  assign sig_out = sig_in << k;
  assign exp_out = exp_in - {5'd0, k};
  // Reports the state after this step so the FSM can leave NORM on the same edge.
  assign done    = sig_out[SIG_W-1];
endmodule

// File: rtl/srt_pre_processing.sv
// SRT divider front end: unpack, classify, normalize subnormals, form sign/exponent.
module srt_pre_processing
  import srt_div_pkg::*;
#(
  parameter int NORM_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] mant_a,
  output logic [23:0] mant_b,
  output logic        resultsign,
  output logic [9:0]  current_exponent,
  output logic        special,
  output logic [31:0] special_result,
  output logic        div_by_zero,
  output logic        invalid
);
  localparam logic [EXP_W-1:0] BIAS_X = EXP_W'(BIAS);

  pre_state_t state_q, state_d;
  ieee754_t [1:0] ops;
  op_class_t ca, cb;
  logic [1:0][SIG_W-1:0] sig_unp, sig_q, sig_nx;
  logic [1:0][EXP_W-1:0] exp_unp, exp_q, exp_nx;
  logic [1:0] done;
  logic sgn, sp_hit, sp_inv, sp_dbz;
  logic [31:0] sp_res;

  assign ops = {divisor, dividend};
  assign ca  = classify(ops[0]);
  assign cb  = classify(ops[1]);
  assign sgn = ops[0].sign ^ ops[1].sign;

  // Lane 0 = dividend, lane 1 = divisor.
  for (genvar i = 0; i < 2; i++) begin : g_op
    assign sig_unp[i] = {ops[i].exp != 8'h00, ops[i].frac};
    assign exp_unp[i] = (ops[i].exp == 8'h00) ? EXP_W'(1) : {2'b00, ops[i].exp};
    norm_step #(.NORM_STEP(NORM_STEP)) u_norm (
      .sig_in (sig_q[i]),
      .exp_in (exp_q[i]),
      .sig_out(sig_nx[i]),
      .exp_out(exp_nx[i]),
      .done   (done[i])
    );
  end

  // Special-case priority: invalid, divide-by-zero, infinite dividend, zero quotient.
  always_comb begin
    sp_hit = 1'b1;
    sp_inv = 1'b0;
    sp_dbz = 1'b0;
    sp_res = '0;
    if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
        (ca == CLS_INF && cb == CLS_INF)) begin
      sp_inv = 1'b1;
      sp_res = QNAN;
    end else if (cb == CLS_ZERO && ca != CLS_INF) begin
      sp_dbz = 1'b1;
      sp_res = {sgn, 8'hFF, 23'h0};
    end else if (ca == CLS_INF) begin
      sp_res = {sgn, 8'hFF, 23'h0};
    end else if (ca == CLS_ZERO || cb == CLS_INF) begin
      sp_res = {sgn, 31'h0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)
              state_d = (sp_hit || (sig_unp[0][SIG_W-1] && sig_unp[1][SIG_W-1])) ? OUT : NORM;
      NORM: if (&done) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q            <= '0;
      exp_q            <= '0;
      current_exponent <= '0;
      resultsign       <= 1'b0;
      special          <= 1'b0;
      special_result   <= '0;
      div_by_zero      <= 1'b0;
      invalid          <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          sig_q            <= sig_unp;
          exp_q            <= exp_unp;
          current_exponent <= exp_unp[0] - exp_unp[1] + BIAS_X;
          resultsign       <= sgn;
          special          <= sp_hit;
          special_result   <= sp_res;
          div_by_zero      <= sp_dbz;
          invalid          <= sp_inv;
        end
        NORM: begin
          sig_q            <= sig_nx;
          exp_q            <= exp_nx;
          current_exponent <= exp_nx[0] - exp_nx[1] + BIAS_X;
        end
        default: ;
      endcase
    end
  end

  assign mant_a    = sig_q[0];
  assign mant_b    = sig_q[1];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
endmodule

// File: tb/tb_srt_pre_processing.sv
// Randomized bench for srt_pre_processing against a behavioural IEEE-754 unpack model.
module tb_srt_pre_processing;
  localparam int NS = 4;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        in_ready, out_valid, resultsign, special, div_by_zero, invalid;
  logic [23:0] mant_a, mant_b;
  logic [9:0]  current_exponent;
  logic [31:0] special_result;
  int checks = 0, errs = 0;

  always #5 clk = ~clk;

  srt_pre_processing #(.NORM_STEP(NS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .mant_a(mant_a), .mant_b(mant_b), .resultsign(resultsign),
    .current_exponent(current_exponent), .special(special), .special_result(special_result),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  typedef struct {
    logic [23:0] ma, mb;
    int          e;
    bit          sg, sp, dbz, inv;
    logic [31:0] sr;
    int          lat;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected result straight from IEEE-754 field rules; normalization one bit at a time.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [31:0] op[2];
    logic [23:0] m;
    int e, lz, lzmax;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    r = '{default: 0};
    nan_a  = a[30:23] == 8'hFF && a[22:0] != 0;
    nan_b  = b[30:23] == 8'hFF && b[22:0] != 0;
    inf_a  = a[30:23] == 8'hFF && a[22:0] == 0;
    inf_b  = b[30:23] == 8'hFF && b[22:0] == 0;
    zero_a = a[30:0] == 0;
    zero_b = b[30:0] == 0;
    r.sg   = a[31] ^ b[31];
    r.sp   = 1;
    r.lat  = 1;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      r.inv = 1; r.sr = 32'h7FC00000;
    end else if (zero_b && !inf_a) begin
      r.dbz = 1; r.sr = {r.sg, 8'hFF, 23'h0};
    end else if (inf_a) r.sr = {r.sg, 8'hFF, 23'h0};
    else if (zero_a || inf_b) r.sr = {r.sg, 31'h0};
    else begin
      r.sp = 0;
      op[0] = a; op[1] = b;
      lzmax = 0;
      r.e = 127;
      for (int i = 0; i < 2; i++) begin
        m  = {op[i][30:23] != 0, op[i][22:0]};
        e  = (op[i][30:23] == 0) ? 1 : int'(op[i][30:23]);
        lz = 0;
        while (!m[23]) begin m = m << 1; e--; lz++; end
        if (lz > lzmax) lzmax = lz;
        if (i == 0) begin r.ma = m; r.e += e; end
        else        begin r.mb = m; r.e -= e; end
      end
      r.lat = 1 + (lzmax + NS - 1) / NS;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    int c;
    x = $urandom;
    c = $urandom_range(0, 9);
    case (c)
      0: x[30:0] = '0;
      1: begin x[30:23] = 8'hFF; x[22:0] = '0; end
      2: begin x[30:23] = 8'hFF; if (x[22:0] == 0) x[0] = 1'b1; end
      3, 4: begin
        x[30:23] = 8'h00;
        x[22:0]  = x[22:0] >> $urandom_range(0, 22);
        if (x[22:0] == 0) x[0] = 1'b1;
      end
      default: if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) x[30:23] = 8'h80;
    endcase
    return x;
  endfunction

  // Single compare process: model pins, reset state, handshake, latency and held outputs.
  exp_t cur, pin;
  bit   pending = 0, first = 0, rst_seen = 0, pins_done = 0;
  int   cnt = 0;

  always @(negedge clk) begin
    if (!pins_done) begin
      pins_done = 1;
      pin = model(32'h40C00000, 32'h40000000);
      chk("pin_6div2_mant", {pin.ma, pin.mb}, {24'hC00000, 24'h800000});
      chk("pin_6div2_exp", pin.e, 128);
      chk("pin_6div2_lat", pin.lat, 1);
      pin = model(32'hC0400000, 32'h3F800000);
      chk("pin_m3div1", {pin.sg, pin.sp, pin.ma}, {1'b1, 1'b0, 24'hC00000});
      pin = model(32'h00000001, 32'h3F800000);
      chk("pin_sub_mant", pin.ma, 24'h800000);
      chk("pin_sub_exp", pin.e, -22);
      chk("pin_sub_lat", pin.lat, 7);
      pin = model(32'h3F800000, 32'h00000000);
      chk("pin_1div0", {pin.sp, pin.dbz, pin.inv, pin.sr}, {3'b110, 32'h7F800000});
      pin = model(32'h00000000, 32'h00000000);
      chk("pin_0div0", {pin.sp, pin.dbz, pin.inv, pin.sr}, {3'b101, 32'h7FC00000});
      pin = model(32'h3F800000, 32'h7F800000);
      chk("pin_1divinf", {pin.sp, pin.dbz, pin.inv, pin.sr}, {3'b100, 32'h00000000});
    end
    if (rst_seen) begin
      chk("reset_mant", {mant_a, mant_b}, 0);
      chk("reset_misc", {resultsign, current_exponent, special, special_result,
                         div_by_zero, invalid}, 0);
    end
    rst_seen = 0;
    chk("in_ready", in_ready, !pending);
    if (pending) begin
      cnt++;
      if (out_valid) begin
        if (first) begin chk("latency", cnt, cur.lat); first = 0; end
        chk("resultsign", resultsign, cur.sg);
        chk("special", special, cur.sp);
        chk("flags_dbz_inv", {div_by_zero, invalid}, {cur.dbz, cur.inv});
        chk("special_result", special_result, cur.sp ? cur.sr : 32'h0);
        if (!cur.sp) begin
          chk("mant_a", mant_a, cur.ma);
          chk("mant_b", mant_b, cur.mb);
          chk("exponent", int'($signed(current_exponent)), cur.e);
        end
        if (out_ready) pending = 0;
      end else if (cnt > cur.lat) begin
        chk("latency_timeout", cnt, cur.lat);
        pending = 0;
      end
    end else begin
      chk("idle_out_valid", out_valid, 0);
    end
    if (rst) begin
      pending  = 0;
      rst_seen = 1;
    end else if (in_valid && in_ready) begin
      cur     = model(dividend, divisor);
      pending = 1;
      first   = 1;
      cnt     = 0;
    end
  end

  // Called only with the DUT idle; stall = extra cycles of out_ready=0 once out_valid is up.
  task automatic xfer(input logic [31:0] a, input logic [31:0] b, input int stall);
    int n;
    n = 0;
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    repeat (stall) begin
      in_valid = 1'b1; dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    xfer(32'h40C00000, 32'h40000000, 0);
    xfer(32'hC0400000, 32'h3F800000, 1);
    xfer(32'h00000001, 32'h3F800000, 0);
    xfer(32'h3F800000, 32'h00000000, 0);
    xfer(32'h00000000, 32'h00000000, 0);
    xfer(32'h3F800000, 32'h7F800000, 0);
    xfer(32'h40C00000, 32'h40000000, 5);
    // Reset during the third NORM cycle of the smallest subnormal.
    dividend = 32'h00000001; divisor = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(32'h40C00000, 32'h40000000, 0);
    for (int i = 0; i < 300; i++)
      xfer(rnd_op(), rnd_op(), $urandom_range(0, 3));
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
